// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux
//  Description : NUM_IN-way valid/ready multiplexer with built-in arbitration
//                (fixed priority or round-robin) feeding a single registered
//                output stage that sustains one beat per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_mux #(
    parameter int WIDTH    = 32,
    parameter int NUM_IN   = 4,
    parameter int ARB_MODE = 1,
    localparam int SEL_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [SEL_W:0]   c_num_in  = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(NUM_IN - 1);

    logic                r_valid;
    logic [WIDTH-1:0]    r_data;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_load;
    logic                w_any;
    logic [SEL_W-1:0]    w_gidx;
    logic [NUM_IN-1:0]   w_grant;
    logic [WIDTH-1:0]    w_sel_data;
    logic                w_xfer;
    logic [SEL_W-1:0]    w_ptr_next;

    // The output register may accept a beat when empty or being drained.
    assign w_load = ~r_valid | out_ready;

    generate
        if (ARB_MODE == 0) begin : g_fixed
            // Fixed priority: scan downwards so the lowest valid index wins.
            always_comb begin
                w_any  = 1'b0;
                w_gidx = '0;
                for (int i = NUM_IN - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        w_any  = 1'b1;
                        w_gidx = SEL_W'(i);
                    end
                end
            end
        end else begin : g_rr
            // Round-robin: search from r_ptr upwards with wrap; scanning the
            // offsets in reverse leaves the smallest offset as the winner.
            always_comb begin
                logic [SEL_W:0] sum;
                sum    = '0;
                w_any  = 1'b0;
                w_gidx = '0;
                for (int k = NUM_IN - 1; k >= 0; k--) begin
                    sum = {1'b0, r_ptr} + (SEL_W+1)'(k);
                    if (sum >= c_num_in) begin
                        sum = sum - c_num_in;
                    end
                    if (in_valid[sum[SEL_W-1:0]]) begin
                        w_any  = 1'b1;
                        w_gidx = sum[SEL_W-1:0];
                    end
                end
            end
        end
    endgenerate

    // Expand the winning index into a one-hot grant and pick its data.
    always_comb begin
        w_grant    = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_any && (w_gidx == SEL_W'(i))) begin
                w_grant[i] = 1'b1;
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is only offered to the granted channel, and never during reset.
    assign in_ready = {NUM_IN{w_load & ~rst}} & w_grant;

    // A transfer happens whenever the granted channel sees ready.
    assign w_xfer = w_load & w_any;

    // Pointer moves to the channel after the one just served, wrapping.
    always_comb begin
        w_ptr_next = '0;
        if (w_gidx != c_last_ch) begin
            w_ptr_next = w_gidx + 1'b1;
        end
    end

    // Output register: capture on transfer, empty when loading with no input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= w_sel_data;
                r_sel   <= w_gidx;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer advances only on a transfer; stays 0 in fixed mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer && (ARB_MODE != 0)) begin
            r_ptr <= w_ptr_next;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_mux
//  Description : Self-checking bench for arb_mux: a fixed-priority and a
//                round-robin 4x32 instance share stimulus and are compared
//                against a behavioural model; a 1x8 instance covers the
//                single-channel case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_mux;

    localparam int W = 32;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic            out_ready;

    logic [N-1:0]    fp_ready, rr_ready;
    logic [W-1:0]    fp_data, rr_data;
    logic [1:0]      fp_sel, rr_sel;
    logic            fp_valid, rr_valid;

    logic [7:0]      one_in_data;
    logic            one_in_valid;
    logic            one_in_ready;
    logic [7:0]      one_out_data;
    logic            one_out_sel;
    logic            one_out_valid;
    logic            one_out_ready;

    logic [N-1:0]    obs_ready [2];
    logic [W-1:0]    obs_data  [2];
    logic [1:0]      obs_sel   [2];
    logic            obs_valid [2];

    // Behavioural model state, one entry per 4-channel instance (0=fixed, 1=rr)
    int              m_valid [2];
    logic [W-1:0]    m_data  [2];
    int              m_sel   [2];
    int              m_ptr   [2];

    int              n_cmp = 0;
    int              n_bad = 0;
    string           nm [2] = '{"fp", "rr"};

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(W), .NUM_IN(N), .ARB_MODE(0)) u_fp (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(fp_ready), .out_data(fp_data), .out_sel(fp_sel),
        .out_valid(fp_valid), .out_ready(out_ready)
    );

    arb_mux #(.WIDTH(W), .NUM_IN(N), .ARB_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rr_ready), .out_data(rr_data), .out_sel(rr_sel),
        .out_valid(rr_valid), .out_ready(out_ready)
    );

    arb_mux #(.WIDTH(8), .NUM_IN(1), .ARB_MODE(1)) u_one (
        .clk(clk), .rst(rst), .in_data(one_in_data), .in_valid(one_in_valid),
        .in_ready(one_in_ready), .out_data(one_out_data), .out_sel(one_out_sel),
        .out_valid(one_out_valid), .out_ready(one_out_ready)
    );

    assign obs_ready[0] = fp_ready;
    assign obs_ready[1] = rr_ready;
    assign obs_data[0]  = fp_data;
    assign obs_data[1]  = rr_data;
    assign obs_sel[0]   = fp_sel;
    assign obs_sel[1]   = rr_sel;
    assign obs_valid[0] = fp_valid;
    assign obs_valid[1] = rr_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Which channel the policy picks: first valid one in search order.
    function automatic int ref_grant(input int mode, input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (mode == 1) ? (ptr + k) % N : k;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0;
            m_data[m]  = '0;
            m_sel[m]   = 0;
            m_ptr[m]   = 0;
        end
    endtask

    // One clock: check ready mid-cycle, advance the model, check outputs after the edge.
    task automatic tick();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            bit          load;
            int          g;
            logic [3:0]  er;
            load = (m_valid[m] == 0) || (out_ready == 1'b1);
            g    = ref_grant(m, m_ptr[m], in_valid);
            er   = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
            check({nm[m], "_in_ready"}, 32'(obs_ready[m]), 32'(er));
            if (load) begin
                if (g >= 0) begin
                    m_valid[m] = 1;
                    m_data[m]  = in_data[g*W +: W];
                    m_sel[m]   = g;
                    if (m == 1) m_ptr[m] = (g + 1) % N;
                end else begin
                    m_valid[m] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check({nm[m], "_out_valid"}, 32'(obs_valid[m]), 32'(m_valid[m]));
            check({nm[m], "_out_data"},  obs_data[m],       m_data[m]);
            check({nm[m], "_out_sel"},   32'(obs_sel[m]),   32'(m_sel[m]));
        end
    endtask

    initial begin
        int exp_seq [5];
        exp_seq = '{0, 1, 2, 3, 0};

        // Reset state, with every input asserting valid
        rst           = 1'b1;
        in_data       = {32'hDEAD_BEEF, 32'h1234_5678, 32'h5555_5555, 32'hAAAA_AAAA};
        in_valid      = 4'b1111;
        out_ready     = 1'b1;
        one_in_data   = 8'h00;
        one_in_valid  = 1'b1;
        one_out_ready = 1'b1;
        model_reset();
        #2;
        check("rst_fp_in_ready", 32'(fp_ready), 32'h0);
        check("rst_rr_in_ready", 32'(rr_ready), 32'h0);
        check("rst_one_in_ready", 32'(one_in_ready), 32'h0);
        check("rst_rr_out_valid", 32'(rr_valid), 32'h0);
        check("rst_rr_out_data", rr_data, 32'h0);
        check("rst_rr_out_sel", 32'(rr_sel), 32'h0);
        check("rst_fp_out_valid", 32'(fp_valid), 32'h0);
        check("rst_one_out_valid", 32'(one_out_valid), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        one_in_valid = 1'b0;
        rst = 1'b0;

        // Round-robin rotation over four continuously valid channels
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_rr_sel_seq", 32'(rr_sel), 32'(exp_seq[i]));
            check("t1_rr_data_seq", rr_data, in_data[exp_seq[i]*W +: W]);
        end

        // Backpressure while holding DEAD_BEEF
        in_valid = 4'b1000;
        tick();
        check("t3_rr_hold_data", rr_data, 32'hDEAD_BEEF);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_bp_data", rr_data, 32'hDEAD_BEEF);
            check("t3_bp_sel", 32'(rr_sel), 32'd3);
            check("t3_bp_ready", 32'(rr_ready), 32'h0);
        end
        out_ready = 1'b1;
        tick();
        check("t3_release_sel", 32'(rr_sel), 32'd0);
        check("t3_release_valid", 32'(rr_valid), 32'd1);

        // Fixed priority with only ch1 and ch3 requesting
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_fp_sel", 32'(fp_sel), 32'd1);
            check("t2_fp_data", fp_data, 32'h5555_5555);
            check("t2_fp_ready3", 32'(fp_ready[3]), 32'd0);
        end

        // Round-robin wrap from ch3 back to ch0
        in_valid = 4'b0100;
        tick();
        check("t4_rr_sel2", 32'(rr_sel), 32'd2);
        in_valid = 4'b1001;
        tick();
        check("t4_rr_sel3", 32'(rr_sel), 32'd3);
        tick();
        check("t4_rr_sel0", 32'(rr_sel), 32'd0);

        // Asynchronous reset in the middle of a stream
        in_valid = 4'b1111;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_rr_valid", 32'(rr_valid), 32'h0);
        check("t5_async_fp_valid", 32'(fp_valid), 32'h0);
        check("t5_async_rr_ready", 32'(rr_ready), 32'h0);
        check("t5_async_fp_ready", 32'(fp_ready), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        check("t5_rst_rr_data", rr_data, 32'h0);
        rst = 1'b0;
        tick();
        check("t5_restart_sel", 32'(rr_sel), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < N; c++) in_data[c*W +: W] = $urandom;
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(3) != 0);
            tick();
        end

        // Single-channel instance behaves as a one-deep register
        in_valid     = 4'b0000;
        one_in_data  = 8'hA5;
        one_in_valid = 1'b1;
        @(negedge clk);
        check("t6_one_ready", 32'(one_in_ready), 32'd1);
        @(posedge clk);
        #1;
        one_in_valid = 1'b0;
        check("t6_one_valid", 32'(one_out_valid), 32'd1);
        check("t6_one_data", 32'(one_out_data), 32'hA5);
        check("t6_one_sel", 32'(one_out_sel), 32'd0);
        @(posedge clk);
        #1;
        check("t6_one_drain", 32'(one_out_valid), 32'd0);
        check("t6_one_hold_data", 32'(one_out_data), 32'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
